// File: rtl/gated_deintegrator_pkg.sv
// Shared types and default widths for the gated deintegrator.
// The stream is rebuilt from n-sample window sums via d[k] = S[k] - S[k-1] + d[k-n].
package gated_deintegrator_pkg;

  localparam int unsigned NBITS_ADDR_DEF     = 6;
  localparam int unsigned NBITS_DATA_IN_DEF  = 20;
  localparam int unsigned NBITS_DATA_OUT_DEF = 14;
  localparam int unsigned N_MIN              = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/gated_deintegrator_if.sv
// Window-sum input stream and reconstructed-sample output stream of the deintegrator.
interface gated_deintegrator_if
  import gated_deintegrator_pkg::*;
#(
  parameter int unsigned P_NBITS_ADDR     = NBITS_ADDR_DEF,
  parameter int unsigned P_NBITS_DATA_IN  = NBITS_DATA_IN_DEF,
  parameter int unsigned P_NBITS_DATA_OUT = NBITS_DATA_OUT_DEF
) ();

  logic [P_NBITS_ADDR-1:0]     n;
  logic                        en;
  logic                        sum_wr;
  logic [P_NBITS_DATA_IN-1:0]  sum;
  logic [P_NBITS_DATA_OUT-1:0] q;
  logic                        q_wr;
  logic                        valid;
  logic                        err;

  modport master (
    output n, en, sum_wr, sum,
    input  q, q_wr, valid, err
  );

  modport slave (
    input  n, en, sum_wr, sum,
    output q, q_wr, valid, err
  );

endinterface

// File: rtl/gated_deintegrator_circ_buf.sv
// Circular store of the last 2^P_NBITS_ADDR reconstructed samples.
// Reads are combinational at (wr_ptr - rd_offset) so the old sample is ready in the accept cycle.
module gated_deintegrator_circ_buf #(
  parameter int unsigned P_NBITS_ADDR = 6,
  parameter int unsigned P_NBITS_DATA = 14
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [P_NBITS_ADDR-1:0] wr_ptr,
  input  logic [P_NBITS_DATA-1:0] wr_data,
  input  logic [P_NBITS_ADDR-1:0] rd_offset,
  output logic [P_NBITS_DATA-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << P_NBITS_ADDR;

  logic [P_NBITS_DATA-1:0] mem_q [DEPTH];
  logic [P_NBITS_ADDR-1:0] rd_addr_s;

  // Pointer difference wraps naturally at the address width.
  assign rd_addr_s = wr_ptr - rd_offset;
  assign rd_data   = mem_q[rd_addr_s];

  // Sample store write port; contents need no reset since FILL never reads them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/gated_deintegrator.sv
// Gated deintegrator: FSM, previous-sum register and reconstruction arithmetic.
// A sample arriving in the cycle en rises is not accepted; the stream starts on the following cycle.
module gated_deintegrator
  import gated_deintegrator_pkg::*;
#(
  parameter int unsigned P_NBITS_ADDR     = NBITS_ADDR_DEF,
  parameter int unsigned P_NBITS_DATA_IN  = NBITS_DATA_IN_DEF,
  parameter int unsigned P_NBITS_DATA_OUT = NBITS_DATA_OUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gated_deintegrator_if.slave  bus
);

  localparam int unsigned EXT = P_NBITS_DATA_IN - P_NBITS_DATA_OUT;

  state_t                      state_q, state_d;
  logic [P_NBITS_DATA_IN-1:0]  prev_sum_q, prev_sum_d;
  logic [P_NBITS_ADDR-1:0]     wr_ptr_q, wr_ptr_d;
  logic [P_NBITS_ADDR-1:0]     count_q, count_d;
  logic [P_NBITS_ADDR-1:0]     n_lat_q, n_lat_d;
  logic                        blocked_q, blocked_d;
  logic [P_NBITS_DATA_OUT-1:0] q_q, q_d;
  logic                        q_wr_q, q_wr_d;
  logic                        valid_q, valid_d;
  logic                        err_q, err_d;

  logic                        buf_we_s;
  logic [P_NBITS_DATA_OUT-1:0] rd_data_s;
  logic [P_NBITS_DATA_IN-1:0]  old_s;
  logic [P_NBITS_DATA_IN-1:0]  d_s;
  logic                        oor_s;
  logic                        n_legal_s;
  logic [P_NBITS_ADDR-1:0]     last_fill_s;

  gated_deintegrator_circ_buf #(
    .P_NBITS_ADDR (P_NBITS_ADDR),
    .P_NBITS_DATA (P_NBITS_DATA_OUT)
  ) u_circ_buf (
    .clk       (clk),
    .we        (buf_we_s),
    .wr_ptr    (wr_ptr_q),
    .wr_data   (d_s[P_NBITS_DATA_OUT-1:0]),
    .rd_offset (n_lat_q),
    .rd_data   (rd_data_s)
  );

  // The d[k-n] term only exists once the buffer holds a full window.
  assign old_s       = (state_q == ST_RUN) ? {{EXT{1'b0}}, rd_data_s} : '0;
  assign d_s         = bus.sum - prev_sum_q + old_s;
  assign oor_s       = |d_s[P_NBITS_DATA_IN-1:P_NBITS_DATA_OUT];
  assign n_legal_s   = (bus.n >= P_NBITS_ADDR'(N_MIN));
  assign last_fill_s = n_lat_q - 1'b1;

  // Next-state and datapath decisions for one cycle.
  always_comb begin
    state_d    = state_q;
    prev_sum_d = prev_sum_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    n_lat_d    = n_lat_q;
    blocked_d  = blocked_q;
    q_d        = q_q;
    q_wr_d     = 1'b0;
    valid_d    = valid_q;
    err_d      = err_q;
    buf_we_s   = 1'b0;
    if (!bus.en) begin
      state_d    = ST_IDLE;
      prev_sum_d = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      valid_d    = 1'b0;
      blocked_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          prev_sum_d = '0;
          wr_ptr_d   = '0;
          count_d    = '0;
          valid_d    = 1'b0;
          // An illegal n parks the block here until en is cycled.
          if (!blocked_q) begin
            n_lat_d = bus.n;
            if (n_legal_s) begin
              state_d = ST_FILL;
            end else begin
              err_d     = 1'b1;
              blocked_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FILL, ST_RUN: begin
          if (bus.sum_wr) begin
            prev_sum_d = bus.sum;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            buf_we_s   = 1'b1;
            q_d        = d_s[P_NBITS_DATA_OUT-1:0];
            q_wr_d     = 1'b1;
            if (oor_s) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (state_q == ST_RUN) begin
              valid_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
              if (count_q == last_fill_s) begin
                state_d = ST_RUN;
              end else begin
                state_d = ST_FILL;
              end
            end
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prev_sum_q <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      n_lat_q    <= '0;
      blocked_q  <= 1'b0;
      q_q        <= '0;
      q_wr_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_sum_q <= prev_sum_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      n_lat_q    <= n_lat_d;
      blocked_q  <= blocked_d;
      q_q        <= q_d;
      q_wr_q     <= q_wr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.q_wr  = q_wr_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_gated_deintegrator.sv
// Directed bench for gated_deintegrator: a stream-level model predicts q/q_wr/valid/err
// from the known source samples, and a per-cycle compare process checks the DUT against it.
module tb_gated_deintegrator;
  import gated_deintegrator_pkg::*;

  localparam int A  = 6;
  localparam int DI = 20;
  localparam int DO = 14;

  typedef struct packed {
    logic          qwr;
    logic [DO-1:0] q;
    logic          valid;
    logic          err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gated_deintegrator_if #(.P_NBITS_ADDR(A), .P_NBITS_DATA_IN(DI), .P_NBITS_DATA_OUT(DO)) bus ();

  gated_deintegrator #(.P_NBITS_ADDR(A), .P_NBITS_DATA_IN(DI), .P_NBITS_DATA_OUT(DO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;
  exp_t exp_next = '0;
  exp_t exp_cur  = '0;

  // stream-level model state
  bit   en_prev_m = 1'b0;
  bit   sess_ok_m = 1'b0;
  bit   err_m     = 1'b0;
  int   acc_m     = 0;
  int   n_lat_m   = 0;

  logic [DO-1:0] src_d [200];

  always @(posedge clk) exp_cur <= exp_next;

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      n_vec++;
      if (bus.q_wr !== exp_cur.qwr || bus.valid !== exp_cur.valid || bus.err !== exp_cur.err ||
          (exp_cur.qwr && bus.q !== exp_cur.q)) begin
        n_bad++;
        $display("FAIL cycle@%0t: got q_wr=%b q=%0d valid=%b err=%b, want q_wr=%b q=%0d valid=%b err=%b",
                 $time, bus.q_wr, bus.q, bus.valid, bus.err,
                 exp_cur.qwr, exp_cur.q, exp_cur.valid, exp_cur.err);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // One input cycle; q_exp is the source sample the accepted sum should reproduce.
  task automatic drive(input bit en_v, input bit wr_v, input logic [DI-1:0] s_v,
                       input logic [DO-1:0] q_exp, input bit oor);
    @(posedge clk);
    #1;
    bus.en     = en_v;
    bus.sum_wr = wr_v;
    bus.sum    = s_v;
    exp_next.qwr = 1'b0;
    exp_next.q   = '0;
    if (!en_v) begin
      sess_ok_m = 1'b0;
      acc_m     = 0;
    end else if (!en_prev_m) begin
      n_lat_m = int'(bus.n);
      acc_m   = 0;
      if (n_lat_m < 2) begin
        sess_ok_m = 1'b0;
        err_m     = 1'b1;
      end else begin
        sess_ok_m = 1'b1;
      end
    end else if (sess_ok_m && wr_v) begin
      exp_next.qwr = 1'b1;
      exp_next.q   = q_exp;
      if (oor) err_m = 1'b1;
      acc_m++;
    end
    exp_next.valid = en_v && sess_ok_m && (acc_m > n_lat_m);
    exp_next.err   = err_m;
    en_prev_m      = en_v;
  endtask

  task automatic idle(input int cycles, input bit en_v);
    for (int i = 0; i < cycles; i++) drive(en_v, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    chk_on     = 1'b0;
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.sum_wr = 1'b0;
    bus.sum    = '0;
    en_prev_m  = 1'b0;
    sess_ok_m  = 1'b0;
    acc_m      = 0;
    err_m      = 1'b0;
    exp_next   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk_on = 1'b1;
  endtask

  int t1_s [8] = '{1, 3, 6, 10, 14, 18, 22, 26};
  int t2_s [4] = '{7, 12, 9, 5};
  int t2_d [4] = '{7, 5, 4, 1};
  int t5_s [4] = '{4, 6, 9, 9};
  int t5_d [4] = '{4, 2, 3, 4};

  initial begin
    bus.n      = '0;
    bus.en     = 1'b0;
    bus.sum_wr = 1'b0;
    bus.sum    = '0;
    apply_reset();
    check("reset_q", 32'(bus.q), 32'd0);
    check("reset_q_wr", 32'(bus.q_wr), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);

    // basic fill, n=4
    bus.n = 6'd4;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 20'(t1_s[i]), 14'(i + 1), 1'b0);
    idle(1, 1'b1);
    check("basic_last_q", 32'(bus.q), 32'd8);
    check("basic_valid", 32'(bus.valid), 32'd1);
    check("basic_err", 32'(bus.err), 32'd0);
    idle(2, 1'b0);

    // minimum window with gaps
    bus.n = 6'd2;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 20'(t2_s[i]), 14'(t2_d[i]), 1'b0);
      idle(i, 1'b1);
    end
    idle(2, 1'b0);

    // long window, pointer wrap, sums near the top of range
    bus.n = 6'd63;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      int acc;
      src_d[k] = 14'($urandom_range(16383, 15000));
      acc = 0;
      for (int j = (k > 62 ? k - 62 : 0); j <= k; j++) acc += int'(src_d[j]);
      drive(1'b1, 1'b1, 20'(acc), src_d[k], 1'b0);
    end
    idle(1, 1'b1);
    check("wrap_err", 32'(bus.err), 32'd0);
    idle(2, 1'b0);

    // mid-run abort, then fresh n=3 session; n change mid-run ignored
    bus.n = 6'd8;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 20'(100 * (i + 1)), 14'd100, 1'b0);
    drive(1'b0, 1'b1, 20'd600, '0, 1'b0);
    idle(1, 1'b0);
    bus.n = 6'd3;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.n = 6'd5;
      drive(1'b1, 1'b1, 20'(t5_s[i]), 14'(t5_d[i]), 1'b0);
    end
    idle(1, 1'b1);
    check("abort_q", 32'(bus.q), 32'd4);
    idle(2, 1'b0);

    // out-of-range detection, sticky through en toggle
    bus.n = 6'd4;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b1, 20'd10, 14'd10, 1'b0);
    drive(1'b1, 1'b1, 20'd20, 14'd10, 1'b0);
    drive(1'b1, 1'b1, 20'd15, 14'd16379, 1'b1);
    idle(1, 1'b1);
    check("oor_err", 32'(bus.err), 32'd1);
    check("oor_q", 32'(bus.q), 32'd16379);
    idle(2, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 20'(t1_s[i]), 14'(i + 1), 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_q_wr", 32'(bus.q_wr), 32'd1);
    check("pre_rst_valid", 32'(bus.valid), 32'd1);
    check("pre_rst_err", 32'(bus.err), 32'd1);
    chk_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_q", 32'(bus.q), 32'd0);
    check("async_rst_q_wr", 32'(bus.q_wr), 32'd0);
    check("async_rst_valid", 32'(bus.valid), 32'd0);
    check("async_rst_err", 32'(bus.err), 32'd0);
    apply_reset();

    // illegal n
    bus.n = 6'd1;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 20'(5 * (i + 1)), '0, 1'b0);
    idle(1, 1'b1);
    check("illegal_n_err", 32'(bus.err), 32'd1);
    check("illegal_n_q_wr", 32'(bus.q_wr), 32'd0);
    idle(2, 1'b0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
